// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu.
// The requester drives operands; the ALU returns the Result with valid/ready flow control.
interface multicycle_alu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            Control;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Result;

    modport master (
        output in_valid, Control, A, B, out_ready,
        input  in_ready, out_valid, Result
    );

    modport slave (
        input  in_valid, Control, A, B, out_ready,
        output in_ready, out_valid, Result
    );
endinterface

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, one radix-2 step per cycle.
module multicycle_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    multicycle_alu_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(W);
    localparam logic [SW-1:0] LAST = SW'(W - 1);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_SLT   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam logic [3:0] OP_REMU  = 4'b1101;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e         state_q, state_d;
    logic [3:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   res_q, res_d;
    logic [SW-1:0]  cnt_q, cnt_d;

    logic [SW-1:0]  shamt;
    logic [W-1:0]   alu_res;
    logic           iter_op;
    logic           is_mul;
    logic [W:0]     mul_sum;
    logic [W-1:0]   mul_hi, mul_lo;
    logic [W:0]     div_r, div_t;
    logic [W-1:0]   div_q, div_rem;

    always_comb begin
        shamt   = bus.B[SW-1:0];
        alu_res = '0;
        iter_op = 1'b0;
        unique case (bus.Control)
            OP_ADD:   alu_res = bus.A + bus.B;
            OP_SUB:   alu_res = bus.A - bus.B;
            OP_AND:   alu_res = bus.A & bus.B;
            OP_OR:    alu_res = bus.A | bus.B;
            OP_XOR:   alu_res = bus.A ^ bus.B;
            OP_SLL:   alu_res = bus.A << shamt;
            OP_SRL:   alu_res = bus.A >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(bus.A) >>> shamt);
            OP_SLTU:  alu_res = {{(W-1){1'b0}}, bus.A < bus.B};
            OP_SLT:   alu_res = {{(W-1){1'b0}},
                                 $signed(bus.A) < $signed(bus.B)};
            OP_MUL, OP_MULHU,
            OP_DIVU, OP_REMU: iter_op = 1'b1;
            default:  alu_res = '0;
        endcase
    end

    // Multiply: acc holds the high half, b shifts out multiplier bits
    // and fills with product bits from the top.
    always_comb begin
        is_mul  = (op_q == OP_MUL) || (op_q == OP_MULHU);
        mul_sum = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_hi  = mul_sum[W:1];
        mul_lo  = {mul_sum[0], b_q[W-1:1]};
        div_r   = {acc_q, a_q[W-1]};
        div_t   = div_r - {1'b0, b_q};
        div_rem = div_t[W] ? div_r[W-1:0] : div_t[W-1:0];
        div_q   = {a_q[W-2:0], ~div_t[W]};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d  = bus.Control;
                    a_d   = bus.A;
                    b_d   = bus.B;
                    acc_d = '0;
                    cnt_d = '0;
                    if (iter_op) begin
                        state_d = CALC;
                    end else begin
                        state_d = DONE;
                        res_d   = alu_res;
                    end
                end
            end
            CALC: begin
                if (is_mul) begin
                    acc_d = mul_hi;
                    b_d   = mul_lo;
                end else begin
                    acc_d = div_rem;
                    a_d   = div_q;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    unique case (op_q)
                        OP_MUL:   res_d = mul_lo;
                        OP_MULHU: res_d = mul_hi;
                        OP_DIVU:  res_d = div_q;
                        default:  res_d = div_rem;
                    endcase
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Result    = res_q;
endmodule
